// File: rtl/alu_pkg.sv
// Purpose : shared op codes, FSM states and helper functions for alu_seq.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
// Optional feature macro: ALU_SEQ_MUL_EN (adds the BUSY state used by the
// iterative multiply).
package alu_pkg;

  localparam int ALU_DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_CMPL = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SLT  = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_e;

  // DONE holds a result for the consumer; BUSY only exists when the
  // multiplier is built.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1
`ifdef ALU_SEQ_MUL_EN
    ,
    ST_BUSY = 2'd2
`endif
  } alu_state_e;

  // Signed overflow of a + b from the three sign bits.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow of a - b, taken directly from the sign bits so that
  // b = most-negative needs no special case.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Purpose : iterative shift-add unsigned multiplier, one bit of b per cycle.
// Latency : done asserts WIDTH cycles after the start cycle; product is 2*WIDTH bits.
// Backpressure: none; the owner must consume product while done is high.
// Ports: clk, rst_n (sync, active-low), start (load a/b and begin),
//        a, b (operands, sampled on start), done (product ready, one cycle),
//        product (full 2*WIDTH-bit product).
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic               run;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // Bit 0 of b is consumed in the start cycle itself, so the counter
  // starts at 1 and reaches WIDTH after WIDTH-1 further steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= CW'(1);
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
    end else if (run) begin
      if (cnt != CNT_LAST) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign done    = run && (cnt == CNT_LAST);
  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Purpose : registered WIDTH-bit ALU (8 ops) with Z/C/V flags and valid/ready on both sides.
// Latency : 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL when ALU_SEQ_MUL_EN is defined.
// Backpressure: result and flags hold while out_valid && !out_ready; in_ready drops until taken.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/op/a/b (request side);
//        out_valid/out_ready/result/zero/carry/overflow (response side).
// Optional feature macro: ALU_SEQ_MUL_EN -- builds the iterative multiplier and
// BUSY state; without it op 111 completes in one cycle with result 0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  alu_state_e state;
  alu_state_e state_nxt;
  alu_state_e accept_state;
  alu_op_e    op_e;
  logic       accept;

  assign op_e      = alu_op_e'(op);
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);

`ifdef ALU_SEQ_MUL_EN
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul       = (op_e == OP_MUL);
  assign mul_start    = accept && is_mul;
  assign accept_state = is_mul ? ST_BUSY : ST_DONE;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign accept_state = ST_DONE;
`endif

  // Single-cycle datapath, evaluated on the live inputs in the accept cycle.
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;

  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (op_e)
      OP_ADD: begin
        res_c   = sum_add[WIDTH-1:0];
        carry_c = sum_add[WIDTH];
        ovf_c   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_add[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = sum_sub[WIDTH-1:0];
        carry_c = sum_sub[WIDTH];
        ovf_c   = sub_ovf(a[WIDTH-1], b[WIDTH-1], sum_sub[WIDTH-1]);
      end
      OP_CMPL: res_c = a[WIDTH-1] ? {1'b1, ~a[WIDTH-2:0]} : a;
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      // MUL: handled by the iterative unit when built, else a zero result.
      OP_MUL:  res_c = '0;
      default: res_c = '0;
    endcase
  end

  // Output registers: loaded on a single-cycle accept or on multiply completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept && (accept_state == ST_DONE)) begin
      result   <= res_c;
      zero     <= ~|res_c;
      carry    <= carry_c;
      overflow <= ovf_c;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (mul_done) begin
      result   <= mul_prod[WIDTH-1:0];
      zero     <= ~|mul_prod[WIDTH-1:0];
      carry    <= |mul_prod[2*WIDTH-1:WIDTH];
      overflow <= 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = accept_state;
        end
      end
      ST_DONE: begin
        // A new accept can only happen here together with out_ready.
        if (out_ready) begin
          state_nxt = accept ? accept_state : ST_IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_BUSY: begin
        if (mul_done) begin
          state_nxt = ST_DONE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Purpose : randomized, scoreboard-checked bench for alu_seq at WIDTH=8.
// Latency : expects 1 cycle for single-cycle ops, WIDTH+1 for MUL when ALU_SEQ_MUL_EN is defined.
// Backpressure: drives out_ready low (directed and random) and checks hold behaviour.
module tb_alu_seq;

  localparam int W = 8;
  localparam int M = 1 << W;
  localparam int H = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit z;
    bit c;
    bit v;
    int lat;
    int acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int o, input int x, input int y);
    exp_t e;
    int sx, sy, s;
    sx = (x >= H) ? x - M : x;
    sy = (y >= H) ? y - M : y;
    e.res = 0; e.c = 0; e.v = 0; e.lat = 1; e.acc = 0;
    case (o)
      0: begin s = x + y; e.res = s % M; e.c = (s >= M); e.v = (sx + sy > H - 1) || (sx + sy < -H); end
      1: begin s = x - y; e.res = (s + M) % M; e.c = (x >= y); e.v = (sx - sy > H - 1) || (sx - sy < -H); end
      2: e.res = (x >= H) ? (3 * H - 1 - x) : x;
      3: e.res = x & y;
      4: e.res = x | y;
      5: e.res = x ^ y;
      6: e.res = (sx < sy) ? 1 : 0;
      default: begin
`ifdef ALU_SEQ_MUL_EN
        s = x * y; e.res = s % M; e.c = (s >= M); e.lat = W + 1;
`endif
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one request and hold it until accepted; pushes the expectation.
  task automatic send(input int o, input int x, input int y, input bit rdy, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o[2:0]; a = x[W-1:0]; b = y[W-1:0];
    if (!rand_rdy) out_ready = rdy;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk); #1; waits++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
    end else begin
      e = model(o, x, y);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return H - 1;
      2: return H;
      3: return M - 1;
      default: return $urandom_range(0, M - 1);
    endcase
  endfunction

  // Monitor: latency on each new output, values on each handshake.
  initial begin
    exp_t e;
    bit pv = 1'b0;
    bit ph = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL stale_out: out_valid=1 result=0x%0h with no outstanding request", result);
        end else begin
          e = q[0];
          if (!pv || ph) check("latency", cyc - e.acc, e.lat);
          if (out_ready) begin
            e = q.pop_front();
            check("result", result, e.res);
            check("flags_zcv", {zero, carry, overflow}, {e.z, e.c, e.v});
          end
        end
      end
      ph = out_valid && out_ready;
      pv = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int dops[8];
    int da[8];
    int db[8];
    dops = '{0, 1, 1, 1, 2, 3, 6, 7};
    da   = '{8'h7F, 8'h00, 8'h80, 8'h00, 8'hF0, 8'h0F, 8'hFF, 8'h10};
    db   = '{8'h01, 8'h01, 8'h01, 8'h80, 8'h00, 8'hF0, 8'h01, 8'h11};

    repeat (3) @(negedge clk);
    #3;
    check("rst_result", result, 0);
    check("rst_flags", {zero, carry, overflow}, 3'b000);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors from the test plan.
    for (int i = 0; i < 8; i++) begin
      send(dops[i], da[i], db[i], 1'b1, w);
      check("accept_wait", w, 0);
`ifdef ALU_SEQ_MUL_EN
      if (dops[i] == 7) begin
        for (int k = 0; k < W; k++) begin
          @(negedge clk); #3;
          check("busy_in_ready", in_ready, 0);
          check("busy_out_valid", out_valid, 0);
        end
      end
`endif
    end

    // Backpressure: hold the ADD result for three cycles, then take it
    // in the same cycle a SUB is accepted.
    send(0, 1, 1, 1'b1, w);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #3;
      check("bp_result", result, 2);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    send(1, 5, 3, 1'b1, w);
    check("bp_accept_wait", w, 0);
    repeat (3) @(negedge clk);

    // Reset in the fourth cycle of a multiply.
    send(7, 8'h10, 8'h11, 1'b1, w);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk); #3;
    check("mrst_result", result, 0);
    check("mrst_flags", {zero, carry, overflow}, 3'b000);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Randomized traffic with random backpressure and idle gaps.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send($urandom_range(0, 7), pick(), pick(), 1'b1, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    check("drain_left", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
